// File: rtl/in_pass4_sync_debounce.sv
// Four-bit input pass BEL: per-bit pass-through, capture, 2-flop sync or sync+debounce, selected by ConfigBits.
// Optional change-pulse output E is built only when INPASS_EDGE_EN is defined (otherwise E is tied low).

module in_pass4_lane #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pad_i,
    input  logic [1:0] mode_i,
    output logic       o_o,
    output logic       e_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r1_q, r2_q;
    logic          d_q, d_d;
    logic [CW-1:0] c_q, c_d;
    logic          sel;

    always_comb begin
        d_d = d_q;
        c_d = c_q;
        if (r2_q == d_q) begin
            c_d = '0;
        end else if (c_q == C_MAX) begin
            d_d = r2_q;
            c_d = '0;
        end else begin
            c_d = c_q + CW'(1);
        end
    end

    // r1 is the only flop allowed to go metastable; everything else sees r2 or later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_q <= 1'b0;
            r2_q <= 1'b0;
            d_q  <= 1'b0;
            c_q  <= '0;
        end else begin
            r1_q <= pad_i;
            r2_q <= r1_q;
            d_q  <= d_d;
            c_q  <= c_d;
        end
    end

    always_comb begin
        sel = pad_i;
        case (mode_i)
            2'b00:   sel = pad_i;
            2'b01:   sel = r1_q;
            2'b10:   sel = r2_q;
            default: sel = d_q;
        endcase
    end

    assign o_o = sel;

`ifdef INPASS_EDGE_EN
    logic prev_q;

    // prev tracks the selected value in every mode, so a mode switch can pulse E once.
    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b0;
        else       prev_q <= sel;
    end

    assign e_o = (mode_i != 2'b00) & (sel ^ prev_q);
`else
    assign e_o = 1'b0;
`endif

endmodule

module in_pass4_sync_debounce #(
    parameter int NoConfigBits    = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    UserCLK,
    input  logic                    RST,
    input  logic [3:0]              I,
    output logic [3:0]              O,
    output logic [3:0]              E,
    input  logic [NoConfigBits-1:0] ConfigBits
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        in_pass4_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk_i (UserCLK),
            .rst_i (RST),
            .pad_i (I[i]),
            .mode_i(ConfigBits[2*i+1:2*i]),
            .o_o   (O[i]),
            .e_o   (E[i])
        );
    end

endmodule

// File: tb/tb_in_pass4_sync_debounce.sv
// Self-checking bench for in_pass4_sync_debounce: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_in_pass4_sync_debounce;
    localparam int N = 4;
`ifdef INPASS_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       UserCLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] I = 4'h0;
    logic [3:0] O, E;
    logic [7:0] ConfigBits = 8'h00;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    in_pass4_sync_debounce #(.NoConfigBits(8), .DEBOUNCE_CYCLES(N)) dut (
        .UserCLK(UserCLK), .RST(RST), .I(I), .O(O), .E(E), .ConfigBits(ConfigBits)
    );

    always #5 UserCLK = ~UserCLK;

    // Behavioural model: flop history, debounce as "N consecutive disagreeing samples".
    bit [3:0] m_r1, m_r2, m_d, m_prev;
    int       m_run [4];

    function automatic bit m_sel(int b);
        case (ConfigBits[2*b +: 2])
            2'd0:    return I[b];
            2'd1:    return m_r1[b];
            2'd2:    return m_r2[b];
            default: return m_d[b];
        endcase
    endfunction

    function automatic logic [3:0] exp_o();
        logic [3:0] v;
        for (int b = 0; b < 4; b++) v[b] = m_sel(b);
        return v;
    endfunction

    function automatic logic [3:0] exp_e();
        logic [3:0] v;
        for (int b = 0; b < 4; b++)
            v[b] = EDGE && (ConfigBits[2*b +: 2] != 2'd0) && (m_sel(b) != m_prev[b]);
        return v;
    endfunction

    initial for (int b = 0; b < 4; b++) m_run[b] = 0;

    always @(posedge UserCLK) begin
        bit [3:0] sel_old;
        for (int b = 0; b < 4; b++) sel_old[b] = m_sel(b);
        if (RST) begin
            m_r1 = '0; m_r2 = '0; m_d = '0; m_prev = '0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (m_r2[b] == m_d[b]) m_run[b] = 0;
                else begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == N) begin
                        m_d[b]   = m_r2[b];
                        m_run[b] = 0;
                    end
                end
            end
            m_prev = sel_old;
            m_r2   = m_r1;
            m_r1   = I;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge UserCLK) begin
        if (cmp_en) begin
            check("model_O", O, exp_o());
            check("model_E", E, exp_e());
        end
    end

    task automatic tick();
        @(posedge UserCLK);
        @(negedge UserCLK);
        #2;
    endtask

    task automatic drive(input logic [3:0] i, input logic [7:0] cfg, input logic rst);
        I = i; ConfigBits = cfg; RST = rst;
    endtask

    initial begin
        // Reset with all bits in capture mode and pads high.
        drive(4'hF, 8'h55, 1'b1);
        tick();
        cmp_en = 1'b1;
        check("rst1_O", O, 4'h0);
        check("rst1_E", E, 4'h0);
        tick();
        check("rst2_O", O, 4'h0);
        check("rst2_E", E, 4'h0);
        drive(4'hF, 8'h55, 1'b0);
        tick();
        check("rel_O", O, 4'hF);
        check("rel_E", E, EDGE ? 4'hF : 4'h0);
        tick();
        check("rel2_O", O, 4'hF);
        check("rel2_E", E, 4'h0);

        // Mode 00: immediate, no pulse.
        drive(4'h0, 8'h54, 1'b0);
        repeat (3) tick();
        I = 4'h1;
        #1;
        check("m00_O", {3'b0, O[0]}, 4'h1);
        check("m00_E", {3'b0, E[0]}, 4'h0);
        tick();
        check("m00_E2", {3'b0, E[0]}, 4'h0);

        // Mode 01: one edge.
        drive(4'h0, 8'h55, 1'b0);
        repeat (3) tick();
        I = 4'h1;
        #1;
        check("m01_O0", {3'b0, O[0]}, 4'h0);
        tick();
        check("m01_O1", {3'b0, O[0]}, 4'h1);
        check("m01_E1", {3'b0, E[0]}, {3'b0, EDGE});
        tick();
        check("m01_E2", {3'b0, E[0]}, 4'h0);

        // Mode 10: two edges.
        drive(4'h0, 8'h56, 1'b0);
        repeat (3) tick();
        I = 4'h1;
        tick();
        check("m10_O1", {3'b0, O[0]}, 4'h0);
        check("m10_E1", {3'b0, E[0]}, 4'h0);
        tick();
        check("m10_O2", {3'b0, O[0]}, 4'h1);
        check("m10_E2", {3'b0, E[0]}, {3'b0, EDGE});
        tick();
        check("m10_E3", {3'b0, E[0]}, 4'h0);

        // Debounce reject: a 3-cycle pulse (one short of N) never reaches D.
        drive(4'h0, 8'h5D, 1'b0);
        repeat (8) tick();
        I = 4'h2;
        repeat (3) tick();
        I = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("deb_rej_O", {3'b0, O[1]}, 4'h0);
            check("deb_rej_E", {3'b0, E[1]}, 4'h0);
        end

        // Debounce accept: O rises exactly 2+N edges after the pad.
        I = 4'h2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("deb_acc_O", {3'b0, O[1]}, (k >= 6) ? 4'h1 : 4'h0);
            check("deb_acc_E", {3'b0, E[1]}, (k == 6 && EDGE) ? 4'h1 : 4'h0);
        end

        // Mode switch 11 -> 00 with D already high, then 00 -> 10 with pad low.
        drive(4'h4, 8'h75, 1'b0);
        repeat (8) tick();
        check("sw_d_O", {3'b0, O[2]}, 4'h1);
        ConfigBits = 8'h45;
        #1;
        check("sw00_O", {3'b0, O[2]}, 4'h1);
        check("sw00_E", {3'b0, E[2]}, 4'h0);
        tick();
        check("sw00_E2", {3'b0, E[2]}, 4'h0);
        drive(4'h0, 8'h65, 1'b0);
        #1;
        check("sw10_O0", {3'b0, O[2]}, 4'h1);
        check("sw10_E0", {3'b0, E[2]}, 4'h0);
        tick();
        check("sw10_O1", {3'b0, O[2]}, 4'h1);
        check("sw10_E1", {3'b0, E[2]}, 4'h0);
        tick();
        check("sw10_O2", {3'b0, O[2]}, 4'h0);
        check("sw10_E2", {3'b0, E[2]}, {3'b0, EDGE});
        tick();
        check("sw10_E3", {3'b0, E[2]}, 4'h0);

        // Random traffic: slowly toggling pads, occasional mode changes and resets.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] ni;
            ni = I;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) ni[b] = ~ni[b];
            I = ni;
            if ($urandom_range(0, 15) == 0) ConfigBits = 8'($urandom);
            RST = ($urandom_range(0, 63) == 0);
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
